// File: rtl/seg7_card_reader_if.sv
// Bundle between a 7-segment sampler and a card-code consumer.
// The master drives segments and card_ready; the slave (reader) returns the card.
interface seg7_card_reader_if;
  logic       sample_en;
  logic [6:0] seg7;
  logic [3:0] card;
  logic       card_valid;
  logic       card_ready;
  logic       bad_pattern;

  modport master (
    output sample_en, seg7, card_ready,
    input  card, card_valid, bad_pattern
  );

  modport slave (
    input  sample_en, seg7, card_ready,
    output card, card_valid, bad_pattern
  );
endinterface

// File: rtl/seg7_card_reader.sv
// Debounces an active-low 7-segment glyph and decodes it back to a card code.
// Reports one cycle after the pattern becomes stable; card is held until card_ready.
module seg7_card_reader #(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic          slow_clock,
  input  logic          resetb,
  seg7_card_reader_if.slave bus
);

  typedef enum logic {TRACK, HOLD} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);
  localparam logic [6:0] BLANK  = 7'b1111111;

  state_t     state, state_nxt;
  logic [6:0] last_sample;
  logic [6:0] last_emitted;
  logic [3:0] run_cnt;
  logic [3:0] card_q;
  logic       bad_q;

  logic       dec_legal;
  logic [3:0] dec_card;
  logic       stable_new;
  logic       load_card;
  logic       mark_emitted;
  logic       flag_bad;

  always_comb begin
    dec_legal = 1'b1;
    dec_card  = 4'd0;
    unique case (last_sample)
      7'b1111111: dec_card = 4'd0;
      7'b0001000: dec_card = 4'd1;
      7'b0100100: dec_card = 4'd2;
      7'b0110000: dec_card = 4'd3;
      7'b0011001: dec_card = 4'd4;
      7'b0010010: dec_card = 4'd5;
      7'b0000010: dec_card = 4'd6;
      7'b1111000: dec_card = 4'd7;
      7'b0000000: dec_card = 4'd8;
      7'b0010000: dec_card = 4'd9;
      7'b1000000: dec_card = 4'd10;
      7'b1100001: dec_card = 4'd11;
      7'b0011000: dec_card = 4'd12;
      7'b0001001: dec_card = 4'd13;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign stable_new = (run_cnt == STABLE) && (last_sample != last_emitted);

  // Run tracking keeps going in HOLD so a pattern settling there is not lost.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      last_sample <= BLANK;
      run_cnt     <= 4'd0;
    end else if (bus.sample_en) begin
      if (bus.seg7 == last_sample) begin
        if (run_cnt < STABLE) run_cnt <= run_cnt + 4'd1;
      end else begin
        last_sample <= bus.seg7;
        run_cnt     <= 4'd1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= TRACK;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TRACK: if (stable_new && dec_legal) state_nxt = HOLD;
      HOLD:  if (bus.card_ready)          state_nxt = TRACK;
      default: state_nxt = TRACK;
    endcase
  end

  always_comb begin
    load_card    = 1'b0;
    mark_emitted = 1'b0;
    flag_bad     = 1'b0;
    if (state == TRACK && stable_new) begin
      mark_emitted = 1'b1;
      load_card    = dec_legal;
      flag_bad     = !dec_legal;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      card_q       <= 4'd0;
      last_emitted <= BLANK;
      bad_q        <= 1'b0;
    end else begin
      if (load_card)    card_q       <= dec_card;
      if (mark_emitted) last_emitted <= last_sample;
      bad_q <= flag_bad;
    end
  end

  assign bus.card        = card_q;
  assign bus.card_valid  = (state == HOLD);
  assign bus.bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_card_reader.sv
// Bench for seg7_card_reader: glyph table, directed corner sequences and random
// traffic, all checked every cycle against a history-based reference model.
module tb_seg7_card_reader;
  localparam int S = 3;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seg7_card_reader_if bus ();

  seg7_card_reader #(.STABLE_CNT(S)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  logic [6:0] glyph [0:13] = '{
    7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b1000000, 7'b1100001, 7'b0011000, 7'b0001001
  };

  // Reference model: a sample history plus the observable report state.
  logic [6:0] hist[$];
  logic [6:0] m_emitted;
  bit         m_valid;
  bit         m_bad;
  logic [3:0] m_card;

  function automatic bit glyph_lookup(input logic [6:0] p, output logic [3:0] c);
    c = 4'd0;
    for (int i = 0; i < 14; i++)
      if (glyph[i] == p) begin
        c = 4'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit tail_stable();
    int n = hist.size();
    if (n < S) return 1'b0;
    for (int i = 1; i < S; i++)
      if (hist[n-1-i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_emitted = 7'b1111111;
    m_valid   = 1'b0;
    m_bad     = 1'b0;
    m_card    = 4'd0;
  endtask

  task automatic model_edge();
    bit         bad_n = 1'b0;
    logic [3:0] c;
    if (m_valid) begin
      if (bus.card_ready) m_valid = 1'b0;
    end else if (tail_stable() && hist[hist.size()-1] != m_emitted) begin
      if (glyph_lookup(hist[hist.size()-1], c)) begin
        m_card  = c;
        m_valid = 1'b1;
      end else begin
        bad_n = 1'b1;
      end
      m_emitted = hist[hist.size()-1];
    end
    m_bad = bad_n;
    if (bus.sample_en) begin
      hist.push_back(bus.seg7);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    if (bus.card_valid !== m_valid || bus.card !== m_card || bus.bad_pattern !== m_bad) begin
      errors++;
      $display("FAIL model[%s] t=%0t: got valid=%b card=%0d bad=%b, want valid=%b card=%0d bad=%b",
               tag, $time, bus.card_valid, bus.card, bus.bad_pattern, m_valid, m_card, m_bad);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic step(input string tag = "cyc");
    @(posedge slow_clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    repeat (2) @(posedge slow_clock);
    #1;
    resetb = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int i = 0; i < budget && !bus.card_valid; i++) step(name);
    check({name, "_timeout"}, int'(bus.card_valid), 1);
  endtask

  typedef struct {
    logic [6:0] pat;
    bit         legal;
    logic [3:0] code;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int nvalid, nbad;
    logic [3:0] seen;
    int cur;

    vecs = '{
      '{7'b0100100, 1'b1, 4'd2},  '{7'b0110000, 1'b1, 4'd3},
      '{7'b0011001, 1'b1, 4'd4},  '{7'b0010010, 1'b1, 4'd5},
      '{7'b0000010, 1'b1, 4'd6},  '{7'b1111000, 1'b1, 4'd7},
      '{7'b0000000, 1'b1, 4'd8},  '{7'b0010000, 1'b1, 4'd9},
      '{7'b1000000, 1'b1, 4'd10}, '{7'b1111111, 1'b1, 4'd0},
      '{7'b1100001, 1'b1, 4'd11}, '{7'b0011000, 1'b1, 4'd12},
      '{7'b0001001, 1'b1, 4'd13}, '{7'b0001000, 1'b1, 4'd1},
      '{7'b0111111, 1'b0, 4'd0},  '{7'b1111110, 1'b0, 4'd0},
      '{7'b0000001, 1'b0, 4'd0}
    };

    bus.sample_en  = 1'b0;
    bus.seg7       = 7'b1111111;
    bus.card_ready = 1'b0;
    #3;
    do_reset();

    // Blank after reset is never reported.
    bus.sample_en = 1'b1;
    nvalid = 0; nbad = 0;
    for (int i = 0; i < 10; i++) begin
      step("blank");
      nvalid += int'(bus.card_valid);
      nbad   += int'(bus.bad_pattern);
    end
    check("blank_valid_cycles", nvalid, 0);
    check("blank_bad_cycles", nbad, 0);

    // Glyph table: S samples, then the report (or bad pulse) on the next edge.
    bus.card_ready = 1'b1;
    for (int v = 0; v < 17; v++) begin
      bus.seg7 = vecs[v].pat;
      repeat (S + 1) step("table");
      check($sformatf("table%0d_valid", v), int'(bus.card_valid), int'(vecs[v].legal));
      check($sformatf("table%0d_bad", v), int'(bus.bad_pattern), int'(!vecs[v].legal));
      if (vecs[v].legal) check($sformatf("table%0d_card", v), int'(bus.card), int'(vecs[v].code));
      step("table");
    end

    // Constant display gives a single report.
    bus.seg7 = 7'b0100100;
    nvalid = 0; seen = 4'd15;
    for (int i = 0; i < S + 21; i++) begin
      step("hold2");
      if (bus.card_valid) begin nvalid++; seen = bus.card; end
    end
    check("const_reports", nvalid, 1);
    check("const_card", int'(seen), 2);

    // Short Q run is skipped; K reported once.
    nvalid = 0; seen = 4'd15;
    for (int i = 0; i < 9; i++) begin
      bus.sample_en = (i < 5);
      bus.seg7 = (i < 2) ? 7'b0011000 : 7'b0001001;
      step("qk");
      if (bus.card_valid) begin nvalid++; seen = bus.card; end
    end
    check("qk_reports", nvalid, 1);
    check("qk_card", int'(seen), 13);

    // Illegal pattern: exactly one bad pulse, no report.
    nvalid = 0; nbad = 0;
    bus.seg7 = 7'b0111111;
    for (int i = 0; i < 6; i++) begin
      bus.sample_en = (i < 3);
      step("illegal");
      nvalid += int'(bus.card_valid);
      nbad   += int'(bus.bad_pattern);
    end
    check("illegal_bad_cycles", nbad, 1);
    check("illegal_valid_cycles", nvalid, 0);

    // Backpressure: card 1 held while 7 settles, then gap, then 7.
    bus.card_ready = 1'b0;
    bus.sample_en  = 1'b1;
    bus.seg7       = 7'b0001000;
    wait_valid(10, "ace");
    check("ace_card", int'(bus.card), 1);
    bus.seg7 = 7'b1111000;
    nbad = 0;
    for (int i = 0; i < 5; i++) begin
      step("hold7");
      if (!bus.card_valid || bus.card != 4'd1) nbad++;
    end
    check("held_card_disturbed", nbad, 0);
    bus.card_ready = 1'b1;
    step("xfer");
    check("gap_valid", int'(bus.card_valid), 0);
    step("after_gap");
    check("seven_valid", int'(bus.card_valid), 1);
    check("seven_card", int'(bus.card), 7);
    step("xfer7");

    // Reset while holding J: discarded, then reported again.
    bus.card_ready = 1'b0;
    bus.seg7 = 7'b1100001;
    wait_valid(10, "jack");
    check("jack_card", int'(bus.card), 11);
    do_reset();
    check("reset_valid", int'(bus.card_valid), 0);
    wait_valid(10, "jack_again");
    check("jack_again_card", int'(bus.card), 11);
    bus.card_ready = 1'b1;
    step("xfer_j");

    // Random traffic against the model.
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 15);
      bus.seg7       = (cur < 14) ? glyph[cur] : ((cur == 14) ? 7'b0111111 : 7'b1010101);
      bus.sample_en  = ($urandom_range(0, 3) != 0);
      bus.card_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 599) == 0) do_reset();
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_card_reader.md
# seg7_card_reader

Recovers card values from a 7-segment display pattern, the inverse of the lab card-to-HEX encoding. Samples a 7-bit active-low segment bus on a strobe, requires the pattern to be stable for a programmable number of consecutive samples, and decodes it back to the 4-bit card code. The decoded card is offered downstream on a valid/ready handshake. It sits beside the baccarat datapath as a self-check monitor on the HEX outputs, or as a front end for a display-driven scoring block.

## Interface
- STABLE_CNT, 3, consecutive identical samples required before a pattern is accepted (legal range 1–15).
- slow_clock  in  1  rising-edge clock; the only clock.
- resetb  in  1  reset, asynchronous, active-low.
- sample_en  in  1  sample strobe; `seg7` is sampled on a rising edge where this is 1.
- seg7  in  7  segment pattern, active-low; bit 0 = a … bit 6 = g.
- card  out  4  decoded card code; 0 = blank, 1 = A, 2–10 = pips, 11 = J, 12 = Q, 13 = K.
- card_valid  out  1  `card` is offered.
- card_ready  in  1  downstream accepts `card`.
- bad_pattern  out  1  one-cycle pulse: a stable pattern was not a legal card glyph.

## Operation
- **Legal patterns** (`seg7` → `card`):
  - 1111111 → 0
  - 0001000 → 1
  - 0100100 → 2
  - 0110000 → 3
  - 0011001 → 4
  - 0010010 → 5
  - 0000010 → 6
  - 1111000 → 7
  - 0000000 → 8
  - 0010000 → 9
  - 1000000 → 10
  - 1100001 → 11
  - 0011000 → 12
  - 0001001 → 13
  - Every other pattern is illegal.
- **Registers:**
  - `last_sample` (7b): most recent sampled pattern.
  - `run_cnt` (4b): length of the current run of identical samples; saturates at STABLE_CNT.
  - `last_emitted` (7b): last stable pattern that was reported.
- **Sampling:** on each sample_en edge:
  - If `seg7` equals `last_sample`, `run_cnt` increments (saturating).
  - Otherwise `last_sample` ← `seg7` and `run_cnt` ← 1.
- **Stable-new condition:** `run_cnt == STABLE_CNT` and `last_sample != last_emitted`.
- **FSM states:** TRACK and HOLD.
  - **TRACK**, stable-new true and pattern legal:
    - Load `card` with the decoded value.
    - Set `last_emitted` ← `last_sample`.
    - Assert card_valid and move to HOLD.
  - **TRACK**, stable-new true and pattern illegal:
    - Pulse bad_pattern for one cycle.
    - Set `last_emitted` ← `last_sample`.
    - Stay in TRACK; card_valid stays 0.
  - **HOLD:**
    - card_valid = 1; `card` is frozen.
    - Sampling continues normally.
    - On an edge where card_ready = 1, card_valid clears and the FSM returns to TRACK.
- **Re-reporting:** a pattern is reported once per change. A display that stays constant produces exactly one report. Blank is reported as card 0 when the display returns to blank from a card.
- **Stabilising during HOLD:** a new pattern that stabilises during HOLD is not lost. It is evaluated in TRACK on the cycle after the handshake, provided it is still stable and differs from `last_emitted`.
- **Changes during HOLD:** if the pattern changes several times during HOLD, only the state at return to TRACK matters.

## Timing
- **Reset values** (asynchronous on resetb = 0):
  - card = 0, card_valid = 0, bad_pattern = 0.
  - `last_sample` = 1111111, `run_cnt` = 0, `last_emitted` = 1111111, state = TRACK.
  - A blank display after reset is therefore never reported.
- **Latency:** if the STABLE_CNT-th identical sample is registered at edge k, then on edge k+1 either card_valid rises or bad_pattern pulses (high for the cycle after edge k+1).
- **Handshake:**
  - Transfer occurs at an edge with card_valid = 1 and card_ready = 1.
  - card_valid is 0 after that edge.
  - The earliest next card_valid is at the following edge (no back-to-back reports in adjacent cycles).
  - card_ready is ignored while card_valid = 0.
  - card_valid never drops without a transfer, except on reset.
- **Simultaneous events:** sample_en and a transfer on the same edge both take effect. The sample updates the tracking registers and does not alter `card`.
- **STABLE_CNT = 1:** every sampled change is reported, after one extra cycle.
- **Reset mid-HOLD:** the pending card is discarded with no transfer. After release, the same pattern is reported again if it is stable and not blank.

## Test plan
- Reset with seg7 = 1111111 and 10 sample_en cycles -> card_valid and bad_pattern stay 0 throughout.
- seg7 = 0100100 for 3 samples, card_ready = 1 -> card_valid pulses one cycle with card = 2. Holding the pattern 20 more samples -> no second report.
- seg7 sequence 0011000, 0011000, 0001001, 0001001, 0001001 (STABLE_CNT = 3) -> a single report, card = 13. The Q run is too short and is never reported.
- seg7 = 0111111 (illegal) for 3 samples -> bad_pattern high exactly one cycle, card_valid stays 0.
- Hold card_ready = 0 after a report of card = 1, then drive 1111000 stable for 5 samples -> card stays 1 and card_valid stays 1. Raise card_ready -> one-cycle gap, then report card = 7.
- Assert resetb = 0 while in HOLD with card = 11, release, keep 1100001 stable -> card_valid is 0 during reset, then card = 11 is reported again.
